pong_game_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 26 ++
 rtl/pong_sec_tick.sv | 31 +++
 rtl/pong_game_ctrl.sv | 152 +++++++++++++++
 tb/tb_pong_game_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types, winner codes and default match settings for the pong match controller.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam int DEF_GAME_SECS  = 60;
  localparam int DEF_WIN_SCORE  = 9;
  localparam int DEF_SERVE_SECS = 2;

  function automatic logic [1:0] judge_winner(input logic [3:0] s1, input logic [3:0] s2);
    if (s1 > s2) return WIN_P1;
    if (s2 > s1) return WIN_P2;
    return WIN_TIE;
  endfunction

endpackage

// File: rtl/pong_sec_tick.sv
// Game-second prescaler: counts 0..CLK_HZ-1 while enabled, pulses sec_tick on the wrap cycle.
module pong_sec_tick #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic sec_tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap     = en && (cnt == CNT_MAX);
  assign sec_tick = wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match controller: scoring, countdown game clock and the idle/serve/play/over sequence.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int GAME_SECS  = DEF_GAME_SECS,
  parameter int WIN_SCORE  = DEF_WIN_SCORE,
  parameter int SERVE_SECS = DEF_SERVE_SECS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       miss1,
  input  logic       miss2,
  output logic       stop,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [3:0] T1_INIT = 4'(GAME_SECS / 10);
  localparam logic [3:0] T0_INIT = 4'(GAME_SECS % 10);
  localparam logic [3:0] WIN_S   = 4'(WIN_SCORE);
  localparam logic [2:0] SERVE_N = 3'(SERVE_SECS);

  state_t     state;
  logic       start_d, miss1_d, miss2_d;
  logic [2:0] serve_cnt;
  logic       sec_tick, presc_en;
  logic       start_rise, m1_rise, m2_rise;
  logic [3:0] s1_nx, s2_nx;
  logic [7:0] t_nx;
  logic       point, enter_serve, enter_over;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN_S) ? WIN_S : s + 4'd1;
  endfunction

  // Ones digit 0 borrows from tens; 00 is held rather than wrapping.
  function automatic logic [7:0] bcd_dec(input logic [3:0] tens, input logic [3:0] ones);
    if (tens == 4'd0 && ones == 4'd0) return 8'h00;
    if (ones == 4'd0) return {tens - 4'd1, 4'd9};
    return {tens, ones - 4'd1};
  endfunction

  assign presc_en = (state == ST_SERVE) || (state == ST_PLAY);

  pong_sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .clk      (clk),
    .rst      (rst),
    .clr      (enter_serve),
    .en       (presc_en),
    .sec_tick (sec_tick)
  );

  always_comb begin
    start_rise  = start & ~start_d;
    m1_rise     = miss1 & ~miss1_d;
    m2_rise     = miss2 & ~miss2_d;
    s1_nx       = score1;
    s2_nx       = score2;
    t_nx        = {sec1, sec0};
    point       = 1'b0;
    enter_serve = 1'b0;
    enter_over  = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: enter_serve = start_rise;
      ST_PLAY: begin
        if (m1_rise && !m2_rise) begin
          s2_nx = sat_inc(score2);
          point = 1'b1;
        end else if (m2_rise && !m1_rise) begin
          s1_nx = sat_inc(score1);
          point = 1'b1;
        end
        if (sec_tick) t_nx = bcd_dec(sec1, sec0);
        // Expiry wins over a re-serve; the score is already folded into s1_nx/s2_nx.
        enter_over  = (t_nx == 8'h00) || (point && ((s1_nx == WIN_S) || (s2_nx == WIN_S)));
        enter_serve = !enter_over && (m1_rise || m2_rise);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      stop      <= 1'b1;
      score1    <= 4'd0;
      score2    <= 4'd0;
      sec1      <= T1_INIT;
      sec0      <= T0_INIT;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
      serve_cnt <= 3'd0;
      start_d   <= 1'b0;
      miss1_d   <= 1'b0;
      miss2_d   <= 1'b0;
    end else begin
      start_d <= start;
      miss1_d <= miss1;
      miss2_d <= miss2;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start_rise) begin
            state     <= ST_SERVE;
            stop      <= 1'b1;
            score1    <= 4'd0;
            score2    <= 4'd0;
            sec1      <= T1_INIT;
            sec0      <= T0_INIT;
            game_over <= 1'b0;
            winner    <= WIN_NONE;
            serve_cnt <= 3'd0;
          end
        end
        ST_SERVE: begin
          if (sec_tick) begin
            if (serve_cnt == SERVE_N - 3'd1) begin
              serve_cnt <= 3'd0;
              state     <= ST_PLAY;
              stop      <= 1'b0;
            end else begin
              serve_cnt <= serve_cnt + 3'd1;
            end
          end
        end
        ST_PLAY: begin
          score1 <= s1_nx;
          score2 <= s2_nx;
          sec1   <= t_nx[7:4];
          sec0   <= t_nx[3:0];
          if (enter_over) begin
            state     <= ST_OVER;
            stop      <= 1'b1;
            game_over <= 1'b1;
            winner    <= judge_winner(s1_nx, s2_nx);
          end else if (enter_serve) begin
            state     <= ST_SERVE;
            stop      <= 1'b1;
            serve_cnt <= 3'd0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed vector table, corner sequences and a random run against a reference model.
module tb_pong_game_ctrl;

  localparam int CLK_HZ     = 10;
  localparam int GAME_SECS  = 12;
  localparam int WIN_SCORE  = 3;
  localparam int SERVE_SECS = 2;

  localparam int PH_IDLE  = 0;
  localparam int PH_SERVE = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_OVER  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, miss1 = 1'b0, miss2 = 1'b0;
  logic       stop, game_over;
  logic [3:0] sec1, sec0, score1, score2;
  logic [1:0] winner;
  logic [19:0] outv;

  int checks = 0;
  int failures = 0;

  pong_game_ctrl #(
    .CLK_HZ(CLK_HZ), .GAME_SECS(GAME_SECS), .WIN_SCORE(WIN_SCORE), .SERVE_SECS(SERVE_SECS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .miss1(miss1), .miss2(miss2),
    .stop(stop), .sec1(sec1), .sec0(sec0), .score1(score1), .score2(score2),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  assign outv = {stop, sec1, sec0, score1, score2, game_over, winner};

  function automatic logic [19:0] pack(input bit st, input int secs, input int s1, input int s2,
                                       input bit go, input int w);
    return {st, 4'(secs / 10), 4'(secs % 10), 4'(s1), 4'(s2), go, 2'(w)};
  endfunction

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (stop,sec1,sec0,s1,s2,go,win)", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; miss1 = 1'b0; miss2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Reference model: seconds as an integer, serve as a cycle countdown, play as cycles into the second.
  typedef struct {
    int ph, secs, s1, s2, win, serve_left, play_cyc;
    bit pst, pm1, pm2;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_rst();
    mstate_t r;
    r.ph = PH_IDLE; r.secs = GAME_SECS; r.s1 = 0; r.s2 = 0; r.win = 0;
    r.serve_left = 0; r.play_cyc = 0; r.pst = 0; r.pm1 = 0; r.pm2 = 0;
    return r;
  endfunction

  function automatic mstate_t model_next(input mstate_t c, input bit st, input bit m1, input bit m2);
    mstate_t n = c;
    bit sr = st && !c.pst;
    bit r1 = m1 && !c.pm1;
    bit r2 = m2 && !c.pm2;
    bit scored = 0;
    bit tick;
    n.pst = st; n.pm1 = m1; n.pm2 = m2;
    case (c.ph)
      PH_IDLE, PH_OVER: if (sr) begin
        n.s1 = 0; n.s2 = 0; n.secs = GAME_SECS; n.win = 0;
        n.ph = PH_SERVE; n.serve_left = SERVE_SECS * CLK_HZ;
      end
      PH_SERVE: begin
        n.serve_left = c.serve_left - 1;
        if (n.serve_left == 0) begin n.ph = PH_PLAY; n.play_cyc = 0; end
      end
      default: begin
        n.play_cyc = c.play_cyc + 1;
        tick = (n.play_cyc == CLK_HZ);
        if (tick) n.play_cyc = 0;
        if (r1 && !r2) begin n.s2 = (c.s2 + 1 > WIN_SCORE) ? WIN_SCORE : c.s2 + 1; scored = 1; end
        else if (r2 && !r1) begin n.s1 = (c.s1 + 1 > WIN_SCORE) ? WIN_SCORE : c.s1 + 1; scored = 1; end
        if (tick && n.secs > 0) n.secs = n.secs - 1;
        if (n.secs == 0 || (scored && (n.s1 == WIN_SCORE || n.s2 == WIN_SCORE))) begin
          n.ph = PH_OVER;
          n.win = (n.s1 > n.s2) ? 1 : (n.s2 > n.s1) ? 2 : 3;
        end else if (r1 || r2) begin
          n.ph = PH_SERVE; n.serve_left = SERVE_SECS * CLK_HZ;
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= model_rst();
    else      m <= model_next(m, start, miss1, miss2);
  end

  typedef struct {
    bit st, m1, m2;
    int cyc;
    bit e_stop;
    int e_secs, e_s1, e_s2;
    bit e_go;
    int e_win;
  } vec_t;

  vec_t vecs[19];

  initial begin
    bit mrate;
    int rate;
    // Serve timing, a 15-cycle miss1 level, then three miss2 points ending the match.
    vecs[0]  = '{0,0,0, 1, 1,12,0,0,0,0};
    vecs[1]  = '{1,0,0, 1, 1,12,0,0,0,0};
    vecs[2]  = '{0,0,0,19, 1,12,0,0,0,0};
    vecs[3]  = '{0,0,0, 1, 0,12,0,0,0,0};
    vecs[4]  = '{0,0,0, 9, 0,12,0,0,0,0};
    vecs[5]  = '{0,0,0, 1, 0,11,0,0,0,0};
    vecs[6]  = '{0,1,0, 1, 1,11,0,1,0,0};
    vecs[7]  = '{0,1,0,14, 1,11,0,1,0,0};
    vecs[8]  = '{0,0,0, 5, 1,11,0,1,0,0};
    vecs[9]  = '{0,0,0, 1, 0,11,0,1,0,0};
    vecs[10] = '{0,0,1, 1, 1,11,1,1,0,0};
    vecs[11] = '{0,0,0,20, 0,11,1,1,0,0};
    vecs[12] = '{0,0,1, 1, 1,11,2,1,0,0};
    vecs[13] = '{0,0,0,20, 0,11,2,1,0,0};
    vecs[14] = '{0,0,1, 1, 1,11,3,1,1,1};
    vecs[15] = '{0,0,0, 3, 1,11,3,1,1,1};
    vecs[16] = '{0,0,1, 2, 1,11,3,1,1,1};
    vecs[17] = '{0,1,0, 2, 1,11,3,1,1,1};
    vecs[18] = '{1,0,0, 1, 1,12,0,0,0,0};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      start = vecs[i].st; miss1 = vecs[i].m1; miss2 = vecs[i].m2;
      step(vecs[i].cyc);
      chk($sformatf("vec%0d", i), outv,
          pack(vecs[i].e_stop, vecs[i].e_secs, vecs[i].e_s1, vecs[i].e_s2, vecs[i].e_go, vecs[i].e_win));
    end

    // Full countdown with no misses ends in a tie.
    do_reset();
    start = 1; step(1); start = 0; step(20);
    chk("cd_play", outv, pack(0, 12, 0, 0, 0, 0));
    for (int k = 1; k <= 12; k++) begin
      step(9);
      chk($sformatf("cd_hold%0d", k), outv, pack(0, 13 - k, 0, 0, 0, 0));
      step(1);
      chk($sformatf("cd_tick%0d", k), outv, pack(k == 12, 12 - k, 0, 0, k == 12, (k == 12) ? 3 : 0));
    end
    step(30);
    chk("cd_floor", outv, pack(1, 0, 0, 0, 1, 3));

    // miss1 lands on the final tick with score2=1.
    do_reset();
    start = 1; step(1); start = 0; step(20);
    miss1 = 1; step(1);
    chk("co_pt1", outv, pack(1, 12, 0, 1, 0, 0));
    miss1 = 0; step(20);
    chk("co_play", outv, pack(0, 12, 0, 1, 0, 0));
    step(119);
    chk("co_01", outv, pack(0, 1, 0, 1, 0, 0));
    miss1 = 1; step(1);
    chk("co_over", outv, pack(1, 0, 0, 2, 1, 2));
    miss1 = 0;

    // Reset dropped mid-rally together with a miss2 rise.
    do_reset();
    start = 1; step(1); start = 0; step(20);
    miss2 = 1; step(1); miss2 = 0; step(20);
    chk("rs_pre", outv, pack(0, 12, 1, 0, 0, 0));
    miss2 = 1; rst = 0; #1;
    chk("rs_async", outv, pack(1, 12, 0, 0, 0, 0));
    step(1);
    chk("rs_hold", outv, pack(1, 12, 0, 0, 0, 0));
    rst = 1; miss2 = 0; step(3);
    chk("rs_idle", outv, pack(1, 12, 0, 0, 0, 0));

    // Random run against the reference model.
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      rate = (i < 2500) ? 14 : 300;
      if ($urandom_range(0, 39) == 0) start = ~start;
      mrate = ($urandom_range(0, rate) == 0);
      if (mrate) miss1 = ~miss1;
      if ($urandom_range(0, rate) == 0) miss2 = ~miss2;
      step(1);
      chk($sformatf("rnd%0d", i), outv,
          pack(m.ph != PH_PLAY, m.secs, m.s1, m.s2, m.ph == PH_OVER, m.win));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
